// File: rtl/comp_seq.sv
// comp_seq: sequential magnitude comparator, one SLICE-wide slice per clock, MSB first, early exit
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a compare (accepted when not busy)
//   signed_mode  1 = two's-complement compare, 0 = unsigned (sampled with start)
//   P, Q         64-bit operands (sampled with start)
//   busy         compare in progress
//   done         one-cycle pulse, result valid
//   OPGTQ/OPEQQ/OPLTQ  registered one-hot result
//   nslices      slices examined for the last result
module comp_seq #(
    parameter int SLICE = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_mode,
    input  logic [63:0] P,
    input  logic [63:0] Q,
    output logic        busy,
    output logic        done,
    output logic        OPGTQ,
    output logic        OPEQQ,
    output logic        OPLTQ,
    output logic [3:0]  nslices
);
    localparam int NS = 64 / SLICE;
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
    state_t      r_state, w_next;
    logic [63:0] r_p, r_q;
    logic        r_sgn;
    logic [3:0]  r_idx;
    logic        r_gt, r_eq, r_lt;
    logic [3:0]  r_ns;
    logic [5:0]  w_base;
    logic [SLICE-1:0] w_ps, w_qs, w_pf, w_qf;
    logic        w_flip, w_last, w_diff, w_gt, w_accept, w_fin;
    assign w_base   = 6'(63 - int'(r_idx) * SLICE);
    assign w_ps     = r_p[w_base -: SLICE];
    assign w_qs     = r_q[w_base -: SLICE];
    // Signed order equals unsigned order once the sign bit is inverted; only the MSB slice holds it.
    assign w_flip   = r_sgn && (r_idx == 4'd0);
    assign w_pf     = {w_ps[SLICE-1] ^ w_flip, w_ps[SLICE-2:0]};
    assign w_qf     = {w_qs[SLICE-1] ^ w_flip, w_qs[SLICE-2:0]};
    assign w_diff   = (w_ps != w_qs);
    assign w_gt     = (w_pf > w_qf);
    assign w_last   = (r_idx == 4'(NS - 1));
    assign w_fin    = (r_state == CMP) && (w_diff || w_last);
    assign w_accept = start && (r_state != CMP);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        busy   = (r_state == CMP);
        done   = (r_state == DONE);
        case (r_state)
            IDLE:    w_next = start ? CMP : IDLE;
            CMP:     w_next = w_fin ? DONE : CMP;
            DONE:    w_next = start ? CMP : IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_q   <= '0;
            r_sgn <= 1'b0;
            r_idx <= '0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
            r_ns  <= '0;
        end else begin
            if (w_accept) begin
                r_p   <= P;
                r_q   <= Q;
                r_sgn <= signed_mode;
                r_idx <= '0;
            end else if (r_state == CMP && !w_fin) begin
                r_idx <= r_idx + 4'd1;
            end
            if (w_fin) begin
                r_gt <= w_diff && w_gt;
                r_eq <= !w_diff;
                r_lt <= w_diff && !w_gt;
                r_ns <= r_idx + 4'd1;
            end
        end
    end
    assign OPGTQ   = r_gt;
    assign OPEQQ   = r_eq;
    assign OPLTQ   = r_lt;
    assign nslices = r_ns;
endmodule

// File: tb/tb_comp_seq.sv
// tb_comp_seq: directed bench for comp_seq at SLICE=8/16/32 against a cycle model
module tb_comp_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st[3], sm[3];
    logic [63:0] pp[3], qq[3];
    logic        bz[3], dn[3], gt[3], eq[3], lt[3];
    logic [3:0]  ns[3];
    int          n_cmp = 0, n_err = 0;
    int          m_left[3];
    logic        m_done[3];
    logic [2:0]  m_res[3], m_pres[3];
    logic [3:0]  m_ns[3], m_pns[3];
    always #5 clk = ~clk;
    for (genvar i = 0; i < 3; i++) begin : g_dut
        comp_seq #(.SLICE(8 << i)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(st[i]), .signed_mode(sm[i]),
            .P(pp[i]), .Q(qq[i]), .busy(bz[i]), .done(dn[i]),
            .OPGTQ(gt[i]), .OPEQQ(eq[i]), .OPLTQ(lt[i]), .nslices(ns[i])
        );
    end
    function automatic logic [2:0] exp_res(logic [63:0] p, logic [63:0] q, logic s);
        if (p == q) return 3'b010;
        if (s ? ($signed(p) > $signed(q)) : (p > q)) return 3'b100;
        return 3'b001;
    endfunction
    function automatic logic [3:0] exp_ns(logic [63:0] p, logic [63:0] q, int sl);
        logic [63:0] d = p ^ q;
        for (int i = 0; i < 64 / sl; i++)
            if (((d << (i * sl)) >> (64 - sl)) != 64'd0) return 4'(i + 1);
        return 4'(64 / sl);
    endfunction
    always @(posedge clk or negedge rst_n) begin
        for (int g = 0; g < 3; g++) begin
            if (!rst_n) begin
                m_left[g] <= 0;
                m_done[g] <= 1'b0;
                m_res[g]  <= 3'b000;
                m_ns[g]   <= 4'd0;
            end else if (st[g] && m_left[g] == 0) begin
                m_left[g] <= int'(exp_ns(pp[g], qq[g], 8 << g));
                m_pres[g] <= exp_res(pp[g], qq[g], sm[g]);
                m_pns[g]  <= exp_ns(pp[g], qq[g], 8 << g);
                m_done[g] <= 1'b0;
            end else if (m_left[g] > 0) begin
                m_left[g] <= m_left[g] - 1;
                if (m_left[g] == 1) begin
                    m_done[g] <= 1'b1;
                    m_res[g]  <= m_pres[g];
                    m_ns[g]   <= m_pns[g];
                end
            end else begin
                m_done[g] <= 1'b0;
            end
        end
    end
    task automatic chk(string nm, int g, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s slice%0d: got %0h expected %0h at %0t", nm, 8 << g, act, exp, $time);
        end
    endtask
    task automatic go(int g, logic [63:0] p, logic [63:0] q, logic s);
        pp[g] = p;
        qq[g] = q;
        sm[g] = s;
        st[g] = 1'b1;
        @(negedge clk);
        st[g] = 1'b0;
    endtask
    task automatic wait_done(int g, output int lat);
        lat = 0;
        while (!dn[g] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!dn[g]) chk("timeout", g, 0, 1);
    endtask
    task automatic res(string nm, int g, logic [2:0] r, logic [3:0] n);
        chk({nm, "_res"}, g, {gt[g], eq[g], lt[g]}, r);
        chk({nm, "_ns"}, g, ns[g], n);
    endtask
    initial begin
        int lat, cnt;
        for (int g = 0; g < 3; g++) begin
            st[g] = 1'b0;
            sm[g] = 1'b0;
            pp[g] = '0;
            qq[g] = '0;
        end
        fork
            forever begin
                @(negedge clk);
                for (int g = 0; g < 3; g++) begin
                    chk("busy", g, bz[g], m_left[g] > 0);
                    chk("done", g, dn[g], m_done[g]);
                    chk("result", g, {gt[g], eq[g], lt[g]}, m_res[g]);
                    chk("nslices", g, ns[g], m_ns[g]);
                end
            end
        join_none
        repeat (2) @(negedge clk);
        res("reset", 0, 3'b000, 4'd0);
        chk("reset_busy", 0, bz[0], 0);
        rst_n = 1'b1;
        @(negedge clk);
        go(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        chk("r030_busy", 0, bz[0], 1);
        wait_done(0, lat);
        chk("r030_lat", 0, lat, 1);
        res("r030", 0, 3'b100, 4'd1);
        @(negedge clk);
        go(0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        wait_done(0, lat);
        res("r031", 0, 3'b001, 4'd1);
        @(negedge clk);
        go(0, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0);
        chk("r032_prev", 0, lt[0], 1);
        wait_done(0, lat);
        chk("r032_lat", 0, lat, 8);
        res("r032", 0, 3'b010, 4'd8);
        @(negedge clk);
        go(0, 64'h1, 64'h0, 1'b0);
        wait_done(0, lat);
        res("r033a", 0, 3'b100, 4'd8);
        go(0, 64'h0, 64'h1, 1'b0);
        chk("r033_busy", 0, bz[0], 1);
        res("r033_hold", 0, 3'b100, 4'd8);
        wait_done(0, lat);
        res("r033b", 0, 3'b001, 4'd8);
        @(negedge clk);
        go(0, 64'h5, 64'h3, 1'b0);
        go(0, 64'h0, 64'h9, 1'b0);
        wait_done(0, lat);
        res("r034", 0, 3'b100, 4'd8);
        @(negedge clk);
        go(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1);
        wait_done(0, lat);
        res("neg", 0, 3'b001, 4'd1);
        @(negedge clk);
        go(0, 64'h0000_0100_0000_0000, 64'h0000_0200_0000_0000, 1'b1);
        wait_done(0, lat);
        res("mid", 0, 3'b001, 4'd3);
        @(negedge clk);
        go(0, 64'h1234, 64'h1234, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("r035_busy", 0, bz[0], 0);
        chk("r035_done", 0, dn[0], 0);
        res("r035", 0, 3'b000, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            cnt += int'(dn[0]);
        end
        chk("r035_nodone", 0, cnt, 0);
        go(0, 64'h0, 64'hFF, 1'b0);
        wait_done(0, lat);
        res("r035_after", 0, 3'b001, 4'd8);
        @(negedge clk);
        for (int g = 1; g < 3; g++) begin
            go(g, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0);
            wait_done(g, lat);
            chk("eq_lat", g, lat, 8 >> g);
            res("eq", g, 3'b010, 4'(8 >> g));
            @(negedge clk);
            go(g, 64'h8000_0000_0000_0000, 64'h0, 1'b1);
            wait_done(g, lat);
            res("sgn", g, 3'b001, 4'd1);
            @(negedge clk);
            go(g, 64'h0000_0000_0001_0000, 64'h0, 1'b0);
            wait_done(g, lat);
            res("low", g, 3'b100, g == 1 ? 4'd3 : 4'd2);
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
